// File: rtl/muldiv_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared types for the iterative RV32M multiply/divide unit:
//               funct3 operation encodings, controller states and the
//               iteration counter width for the default datapath width.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  // Default datapath width; the counter width follows from it.
  localparam int MULDIV_DATA_WIDTH = 32;
  localparam int CNT_W             = $clog2(MULDIV_DATA_WIDTH);

  // RV32M funct3 encodings.
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

endpackage
`default_nettype wire

// File: rtl/execute_muldiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : execute_muldiv_unit
// Description : Iterative RV32M multiply/divide unit in the execute stage.
//               One radix-2 step per cycle (shift-add multiply, restoring
//               divide) on operand magnitudes, with sign fix-up applied when
//               the registered result is written on entry to DONE. Divide by
//               zero and signed overflow resolve at accept and skip the loop.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REGISTER_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_i,
  input  logic                      muldiv_e_i,
  input  logic [2:0]                muldiv_op_e_i,
  input  logic [DATA_WIDTH-1:0]     src_a_e_i,
  input  logic [DATA_WIDTH-1:0]     src_b_e_i,
  input  logic [REGISTER_WIDTH-1:0] rd_e_i,
  input  logic                      flush_i,
  output logic                      stall_o,
  output logic                      done_o,
  output logic [DATA_WIDTH-1:0]     result_o,
  output logic [REGISTER_WIDTH-1:0] rd_o
);

  localparam int                  CNT_BITS  = $clog2(DATA_WIDTH);
  localparam logic [CNT_BITS-1:0] LAST_ITER = CNT_BITS'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] INT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Two's-complement negate of a double-width value when requested.
  function automatic logic [2*DATA_WIDTH-1:0] sign_fix(
    input logic [2*DATA_WIDTH-1:0] value,
    input logic                    negate
  );
    sign_fix = negate ? -value : value;
  endfunction

  // Controller state
  muldiv_state_t state_q;
  muldiv_state_t state_d;

  // Operation context latched at accept
  logic [CNT_BITS-1:0]       cnt_q;
  muldiv_op_t                op_q;
  logic [REGISTER_WIDTH-1:0] rd_q;
  logic                      sign_a_q;
  logic                      sign_b_q;
  // Multiplicand (MUL) or divisor (DIV) magnitude
  logic [DATA_WIDTH-1:0]     opnd_q;
  // MUL: {partial high, remaining multiplier}; DIV: {remainder, quotient}
  logic [2*DATA_WIDTH-1:0]   acc_q;

  // Accept-time decode
  muldiv_op_t                op_in;
  logic                      a_signed;
  logic                      b_signed;
  logic                      neg_a;
  logic                      neg_b;
  logic [DATA_WIDTH-1:0]     mag_a;
  logic [DATA_WIDTH-1:0]     mag_b;
  logic                      div_by_zero;
  logic                      div_overflow;
  logic                      special;
  logic [DATA_WIDTH-1:0]     special_result;
  logic                      accept;
  logic                      last_iter;

  // Iteration datapath
  logic [DATA_WIDTH:0]       mul_sum;
  logic [2*DATA_WIDTH-1:0]   mul_next;
  logic [DATA_WIDTH:0]       div_trial;
  logic [2*DATA_WIDTH-1:0]   div_next;
  logic [2*DATA_WIDTH-1:0]   acc_next;

  // Final sign fix-up and result selection
  logic [2*DATA_WIDTH-1:0]   fix_value;
  logic                      fix_negate;
  logic [2*DATA_WIDTH-1:0]   fixed_value;
  logic [DATA_WIDTH-1:0]     final_result;

  assign op_in     = muldiv_op_t'(muldiv_op_e_i);
  assign accept    = (state_q == IDLE) && muldiv_e_i && !flush_i;
  assign last_iter = (cnt_q == LAST_ITER);

  // Which operands are interpreted as signed for the incoming op
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op_in)
      OP_MULH, OP_DIV, OP_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      OP_MULHSU: a_signed = 1'b1;
      default: begin
        a_signed = 1'b0;
        b_signed = 1'b0;
      end
    endcase
  end

  assign neg_a = a_signed & src_a_e_i[DATA_WIDTH-1];
  assign neg_b = b_signed & src_b_e_i[DATA_WIDTH-1];
  assign mag_a = neg_a ? -src_a_e_i : src_a_e_i;
  assign mag_b = neg_b ? -src_b_e_i : src_b_e_i;

  // Divide corner cases are answered directly without iterating.
  assign div_by_zero  = (src_b_e_i == '0);
  assign div_overflow = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                        (src_a_e_i == INT_MIN) && (&src_b_e_i);
  assign special      = muldiv_op_e_i[2] && (div_by_zero || div_overflow);
  // funct3 bit 1 selects the remainder variants of the divide group
  assign special_result = div_by_zero ? (muldiv_op_e_i[1] ? src_a_e_i : '1)
                                      : (muldiv_op_e_i[1] ? '0 : INT_MIN);

  // Shift-add step: conditionally add the multiplicand to the high half,
  // then shift the whole accumulator right, carry included.
  assign mul_sum  = {1'b0, acc_q[2*DATA_WIDTH-1:DATA_WIDTH]} +
                    (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[DATA_WIDTH-1:1]};

  // Restoring step: shift the next dividend bit into the remainder and
  // keep the subtraction only when it does not borrow.
  assign div_trial = {acc_q[2*DATA_WIDTH-1:DATA_WIDTH], acc_q[DATA_WIDTH-1]} -
                     {1'b0, opnd_q};
  assign div_next  = div_trial[DATA_WIDTH]
                   ? {acc_q[2*DATA_WIDTH-2:0], 1'b0}
                   : {div_trial[DATA_WIDTH-1:0], acc_q[DATA_WIDTH-2:0], 1'b1};

  assign acc_next = (state_q == DIV) ? div_next : mul_next;

  // Place the value to be sign-corrected in a double-width word so a single
  // negate serves the product, the quotient and the remainder.
  always_comb begin
    fix_value  = acc_next;
    fix_negate = sign_a_q ^ sign_b_q;
    if (state_q == DIV) begin
      if (op_q[1]) begin
        fix_value  = {acc_next[2*DATA_WIDTH-1:DATA_WIDTH], {DATA_WIDTH{1'b0}}};
        fix_negate = sign_a_q;
      end else begin
        fix_value  = {acc_next[DATA_WIDTH-1:0], {DATA_WIDTH{1'b0}}};
      end
    end
  end

  assign fixed_value  = sign_fix(fix_value, fix_negate);
  assign final_result = (op_q == OP_MUL) ? fixed_value[DATA_WIDTH-1:0]
                                         : fixed_value[2*DATA_WIDTH-1:DATA_WIDTH];

  // State register
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (special) begin
            state_d = DONE;
          end else if (muldiv_op_e_i[2]) begin
            state_d = DIV;
          end else begin
            state_d = MUL;
          end
        end
      end
      MUL, DIV: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (last_iter) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Front-of-pipeline stall: from the accept cycle through the last iteration
  always_comb begin
    stall_o = 1'b0;
    case (state_q)
      IDLE:     stall_o = muldiv_e_i && !flush_i;
      MUL, DIV: stall_o = 1'b1;
      default:  stall_o = 1'b0;
    endcase
  end

  // Operand latch, iteration and registered result
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      rd_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_o <= '0;
      rd_o     <= '0;
      done_o   <= 1'b0;
    end else begin
      // DONE always lasts one cycle, so entering it is the only way to be there.
      done_o <= (state_d == DONE);
      if (accept) begin
        cnt_q    <= '0;
        op_q     <= op_in;
        rd_q     <= rd_e_i;
        sign_a_q <= neg_a;
        sign_b_q <= neg_b;
        if (muldiv_op_e_i[2]) begin
          opnd_q <= mag_b;
          acc_q  <= {{DATA_WIDTH{1'b0}}, mag_a};
        end else begin
          opnd_q <= mag_a;
          acc_q  <= {{DATA_WIDTH{1'b0}}, mag_b};
        end
        if (special) begin
          result_o <= special_result;
          rd_o     <= rd_e_i;
        end
      end else if (((state_q == MUL) || (state_q == DIV)) && !flush_i) begin
        acc_q <= acc_next;
        cnt_q <= cnt_q + CNT_BITS'(1);
        if (last_iter) begin
          result_o <= final_result;
          rd_o     <= rd_q;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_execute_muldiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_execute_muldiv_unit
// Description : Directed self-checking bench for execute_muldiv_unit. A small
//               ID/EX model advances the presented instruction whenever the
//               unit is not stalling; latency, stall length, result and rd
//               are compared against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        muldiv_e_i;
  logic [2:0]  muldiv_op_e_i;
  logic [31:0] src_a_e_i;
  logic [31:0] src_b_e_i;
  logic [4:0]  rd_e_i;
  logic        flush_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  always #5 clk = ~clk;

  execute_muldiv_unit #(
    .DATA_WIDTH     (32),
    .REGISTER_WIDTH (5)
  ) dut (
    .clk           (clk),
    .rst_i         (rst_i),
    .muldiv_e_i    (muldiv_e_i),
    .muldiv_op_e_i (muldiv_op_e_i),
    .src_a_e_i     (src_a_e_i),
    .src_b_e_i     (src_b_e_i),
    .rd_e_i        (rd_e_i),
    .flush_i       (flush_i),
    .stall_o       (stall_o),
    .done_o        (done_o),
    .result_o      (result_o),
    .rd_o          (rd_o)
  );

  int tests = 0;
  int fails = 0;

  // Instruction sequence presented through the ID/EX model
  logic [2:0]  seq_op [2];
  logic [31:0] seq_a  [2];
  logic [31:0] seq_b  [2];
  logic [4:0]  seq_rd [2];

  // Observations from the last sequence
  int          stall_cnt;
  int          done_cnt;
  int          done_cyc [2];
  logic [31:0] done_res [2];
  logic [4:0]  done_rd  [2];
  int          done_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge. Presents seq[0..n-1]; each instruction
  // leaves ID/EX on the first edge where stall_o was low.
  task automatic run_seq(input int n, input int ncyc);
    int idx;
    bit adv;
    stall_cnt   = 0;
    done_cnt    = 0;
    done_cyc[0] = -1;
    done_cyc[1] = -1;
    done_res[0] = '0;
    done_res[1] = '0;
    done_rd[0]  = '0;
    done_rd[1]  = '0;
    idx = 0;
    muldiv_op_e_i = seq_op[0];
    src_a_e_i     = seq_a[0];
    src_b_e_i     = seq_b[0];
    rd_e_i        = seq_rd[0];
    muldiv_e_i    = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (stall_o) stall_cnt++;
      if (done_o) begin
        if (done_cnt < 2) begin
          done_cyc[done_cnt] = c;
          done_res[done_cnt] = result_o;
          done_rd[done_cnt]  = rd_o;
        end
        done_cnt++;
      end
      adv = muldiv_e_i && !stall_o;
      @(posedge clk);
      #1;
      if (adv) begin
        idx++;
        if (idx < n) begin
          muldiv_op_e_i = seq_op[idx];
          src_a_e_i     = seq_a[idx];
          src_b_e_i     = seq_b[idx];
          rd_e_i        = seq_rd[idx];
        end else begin
          muldiv_e_i = 1'b0;
        end
      end
    end
  endtask

  // One instruction: lat is both the stall length and the done cycle index
  task automatic single(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int lat);
    seq_op[0] = op;
    seq_a[0]  = a;
    seq_b[0]  = b;
    seq_rd[0] = rd;
    run_seq(1, 40);
    check({tag, " done_count"}, done_cnt, 1);
    check({tag, " done_cycle"}, done_cyc[0], lat);
    check({tag, " stall_cycles"}, stall_cnt, lat);
    check({tag, " result"}, done_res[0], exp);
    check({tag, " rd"}, {27'd0, done_rd[0]}, {27'd0, rd});
  endtask

  // Count done pulses over a number of cycles with no instruction presented
  task automatic watch_idle(input int ncyc);
    done_seen = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (done_o) done_seen++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_i         = 1'b1;
    muldiv_e_i    = 1'b0;
    muldiv_op_e_i = 3'b000;
    src_a_e_i     = '0;
    src_b_e_i     = '0;
    rd_e_i        = '0;
    flush_i       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset result", result_o, 32'h0);
    check("reset rd", {27'd0, rd_o}, 32'h0);
    check("reset done", {31'd0, done_o}, 32'h0);
    check("reset stall", {31'd0, stall_o}, 32'h0);
    rst_i = 1'b0;
    @(posedge clk);
    #1;

    // Iterative multiplies
    single("mul",    3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33);
    single("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 33);
    single("mulh",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 33);
    single("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 5'd8,  32'hFFFF_FFFF, 33);

    // Iterative divides
    single("div",    3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'hFFFF_FFFD, 33);
    single("rem",    3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd11, 32'hFFFF_FFFF, 33);
    single("divu",   3'b101, 32'd100,       32'd7,         5'd12, 32'd14,        33);
    single("remu",   3'b111, 32'd100,       32'd7,         5'd13, 32'd2,         33);

    // Special cases resolved at accept
    single("divu_by0", 3'b101, 32'd5,         32'd0,         5'd14, 32'hFFFF_FFFF, 1);
    single("remu_by0", 3'b111, 32'd5,         32'd0,         5'd15, 32'd5,         1);
    single("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1);
    single("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0000_0000, 1);
    single("rem_by0",  3'b110, 32'hFFFF_FFF9, 32'd0,         5'd0,  32'hFFFF_FFF9, 1);

    // Back-to-back: DIV waits in ID/EX until the MUL reaches DONE
    seq_op[0] = 3'b000; seq_a[0] = 32'h0000_0007; seq_b[0] = 32'hFFFF_FFFD; seq_rd[0] = 5'd5;
    seq_op[1] = 3'b100; seq_a[1] = 32'hFFFF_FFF9; seq_b[1] = 32'h0000_0002; seq_rd[1] = 5'd9;
    run_seq(2, 80);
    check("b2b done_count", done_cnt, 2);
    check("b2b first_cycle", done_cyc[0], 33);
    check("b2b second_cycle", done_cyc[1], 67);
    check("b2b first_result", done_res[0], 32'hFFFF_FFEB);
    check("b2b second_result", done_res[1], 32'hFFFF_FFFD);
    check("b2b second_rd", {27'd0, done_rd[1]}, 32'd9);
    check("b2b stall_cycles", stall_cnt, 66);

    // Flush mid-multiply: back to IDLE, previous result retained
    muldiv_op_e_i = 3'b000;
    src_a_e_i     = 32'd7;
    src_b_e_i     = 32'd3;
    rd_e_i        = 5'd12;
    muldiv_e_i    = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    flush_i    = 1'b1;
    muldiv_e_i = 1'b0;
    @(negedge clk);
    check("flush busy_before", {31'd0, stall_o}, 32'd1);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    @(negedge clk);
    check("flush idle_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk);
    #1;
    watch_idle(40);
    check("flush no_done", done_seen, 0);
    check("flush result_kept", result_o, 32'hFFFF_FFFD);
    check("flush rd_kept", {27'd0, rd_o}, 32'd9);

    // Asynchronous reset mid-multiply
    muldiv_op_e_i = 3'b000;
    src_a_e_i     = 32'd7;
    src_b_e_i     = 32'd3;
    rd_e_i        = 5'd3;
    muldiv_e_i    = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2;
    rst_i      = 1'b1;
    muldiv_e_i = 1'b0;
    #1;
    check("arst result", result_o, 32'h0);
    check("arst rd", {27'd0, rd_o}, 32'h0);
    check("arst done", {31'd0, done_o}, 32'h0);
    check("arst stall", {31'd0, stall_o}, 32'h0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    watch_idle(40);
    check("arst no_done", done_seen, 0);
    check("arst result_held", result_o, 32'h0);

    // Unit operates normally after reset
    single("post_rst_remu", 3'b111, 32'd100, 32'd7, 5'd21, 32'd2, 33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/execute_muldiv_unit.md
Name: execute_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage; consumes operands and control from the ID/EX pipeline register.
- Runs one radix-2 iteration per cycle. Stalls the front of the pipeline (PC, IF/ID, ID/EX) while busy.
- Hands one registered result to the execute-stage result mux for the EX/MEM register.

Parameters:
- DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.
- REGISTER_WIDTH, 5, destination register index width.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- muldiv_e_i  input  1  instruction in execute is RV32M.
- muldiv_op_e_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- src_a_e_i  input  DATA_WIDTH  forwarded rs1 value.
- src_b_e_i  input  DATA_WIDTH  forwarded rs2 value.
- rd_e_i  input  REGISTER_WIDTH  destination register.
- flush_i  input  1  abort current operation.
- stall_o  output  1  hold PC, IF/ID and ID/EX.
- done_o  output  1  result valid this cycle.
- result_o  output  DATA_WIDTH  final result.
- rd_o  output  REGISTER_WIDTH  destination of result.

Behaviour:
- Reset (async, rst_i=1): state IDLE; counter, accumulators, result_o, rd_o and done_o all 0. stall_o is 0 after reset.
- States and transitions:
  - IDLE → MUL on accept of op 0xx.
  - IDLE → DIV on accept of op 1xx, non-special.
  - IDLE → DONE on accept of a special-case divide.
  - MUL/DIV → DONE when counter reaches DATA_WIDTH-1 (after the last iteration).
  - DONE → IDLE unconditionally.
- Accept: state==IDLE && muldiv_e_i && !flush_i. On accept, latch:
  - operand magnitudes;
  - sign flags: a signed for MULH/MULHSU/DIV/REM; b signed for MULH/DIV/REM;
  - op and rd_e_i;
  - counter cleared to 0.
- stall_o is combinational and equals (IDLE && muldiv_e_i && !flush_i) || MUL || DIV. It is 0 in DONE, so ID/EX advances on the DONE edge. muldiv_e_i seen in DONE is ignored.
- MUL iteration: unsigned shift-add of magnitudes into a 2*DATA_WIDTH product.
  - In DONE, the product is negated if sign_a XOR sign_b.
  - Result: MUL takes the low half; MULH/MULHSU/MULHU take the high half.
- DIV iteration: restoring division of magnitudes.
  - Quotient is negated if sign_a XOR sign_b.
  - Remainder takes the sign of the dividend.
- Special cases, resolved at accept (next cycle is DONE):
  - Divisor 0: DIV/DIVU give all ones; REM/REMU give the dividend.
  - Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- Latency:
  - Iterative op accepted at edge t: done_o high during cycle t+DATA_WIDTH+1 (cycle 33), exactly 1 cycle. stall_o high for DATA_WIDTH+1 cycles.
  - Special case: done_o one cycle after accept; stall_o high for 1 cycle.
- result_o and rd_o are registered. They are written on entry to DONE and hold their value until the next DONE. done_o is registered.
- flush_i in MUL/DIV: next state IDLE; result_o/rd_o unchanged; no done_o. flush_i in DONE: done_o is still produced; the downstream stage discards it.
- Reset mid-operation: immediate return to IDLE; no done_o.
- x0 destination is computed normally; write suppression happens in the register file.

Decomposition:
- Shared package muldiv_pkg:
  - muldiv_op_t enum for funct3 encodings;
  - muldiv_state_t {IDLE, MUL, DIV, DONE};
  - localparam CNT_W = $clog2(DATA_WIDTH).
- Single module with no sub-module. Sign fix-up is a local function.

Test Plan:
- MUL 7 × 0xFFFFFFFD → stall_o high 33 cycles; done_o at cycle 33; result_o 0xFFFFFFEB; rd_o echoes rd_e_i=5.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → result_o 0xFFFFFFFE. MULH with the same operands → 0x00000000. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. Each with done_o one cycle after accept and stall_o high exactly 1 cycle.
- Back-to-back: MUL then DIV held in ID/EX → second accepted the cycle after DONE; no lost or duplicated done_o.
- rst_i pulsed at iteration 10 → all outputs 0 asynchronously; no done_o. flush_i at iteration 20 → IDLE next cycle; result_o keeps its previous value.
